// File: rtl/host_snapshot_buffer_if.sv
// Host snapshot buffer bus: capture stream from the collision pipeline,
// host read port and frame status. The master drives the pipeline and
// host inputs; the buffer itself sits on the slave side.
interface host_snapshot_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int NUM_CH     = 3
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                         frame_start;
  logic                         in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic                         host_lock;
  logic                         host_rd_en;
  logic [ADDR_WIDTH:0]          host_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         frame_ready;
  logic [7:0]                   frame_id;
  logic [15:0]                  drop_count;
  logic                         busy;

  modport master (
    output frame_start, in_valid, in_data, host_lock, host_rd_en, host_addr,
    input  rd_data, rd_valid, frame_ready, frame_id, drop_count, busy
  );

  modport slave (
    input  frame_start, in_valid, in_data, host_lock, host_rd_en, host_addr,
    output rd_data, rd_valid, frame_ready, frame_id, drop_count, busy
  );
endinterface

// File: rtl/host_snapshot_buffer.sv
// Ping-pong frame store between the collision pipeline and the host link.
// One bank captures the current pass while the host reads the other; banks
// swap only when a full frame has landed and the host is not holding the
// read bank, so the host never sees a torn frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for frame_start, incoming pixels ignored
// CAPTURE | writing pixels in raster order into the write bank
// PENDING | frame complete but host_lock held; write bank frozen,
//         | incoming pixels dropped and counted
module host_snapshot_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int NUM_CH     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  host_snapshot_buffer_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int WORD_WIDTH = NUM_CH * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   BANK_OFS = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    wr_en;
  logic                    swap;
  logic                    drop;
  logic                    wr_bank, rd_bank;
  logic                    lock_q;
  logic                    lock_rise;
  logic                    frame_ready;
  logic [7:0]              frame_id;
  logic [15:0]             drop_count;
  logic [WORD_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic [ADDR_WIDTH:0]     wr_index, rd_index;
  logic                    rd_oor;

  // Banks sit back to back: bank 0 at [0, DEPTH), bank 1 at [DEPTH, 2*DEPTH).
  logic [WORD_WIDTH-1:0]   mem [0:2*DEPTH-1];

  assign lock_rise = bus.host_lock & ~lock_q;
  assign rd_oor    = (bus.host_addr >= BANK_OFS);
  assign wr_index  = {1'b0, wr_addr} + (wr_bank ? BANK_OFS : '0);
  assign rd_index  = {1'b0, bus.host_addr[ADDR_WIDTH-1:0]} + (rd_bank ? BANK_OFS : '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end

  // Next-state, write strobe and swap decision.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wr_addr    = wr_ptr;
    wr_en      = 1'b0;
    swap       = 1'b0;
    drop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.frame_start) begin
          state_nxt  = S_CAPTURE;
          wr_ptr_nxt = '0;
        end
      end
      S_CAPTURE: begin
        if (bus.frame_start) begin
          // Restart: the partial frame is abandoned; a pixel arriving with
          // the restart is pixel 0 of the new pass.
          wr_addr    = '0;
          wr_en      = bus.in_valid;
          wr_ptr_nxt = bus.in_valid ? ADDR_WIDTH'(1) : '0;
        end else if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_PIX) begin
            wr_ptr_nxt = '0;
            if (bus.host_lock) begin
              state_nxt = S_PENDING;
            end else begin
              state_nxt = S_IDLE;
              swap      = 1'b1;
            end
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end
      S_PENDING: begin
        drop = bus.in_valid;
        if (!bus.host_lock) begin
          state_nxt = S_IDLE;
          swap      = 1'b1;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        wr_ptr_nxt = '0;
      end
    endcase
  end

  // Bank selects and host-facing frame status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      lock_q      <= 1'b0;
      frame_ready <= 1'b0;
      frame_id    <= 8'd0;
      drop_count  <= 16'd0;
    end else begin
      lock_q <= bus.host_lock;
      if (swap) begin
        wr_bank  <= ~wr_bank;
        rd_bank  <= ~rd_bank;
        frame_id <= frame_id + 8'd1;
      end
      // A swap coinciding with the acknowledge edge leaves the new frame flagged.
      if (swap) begin
        frame_ready <= 1'b1;
      end else if (lock_rise) begin
        frame_ready <= 1'b0;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Capture write port; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= bus.in_data;
    end
  end

  // Host read port: one-cycle latency, data held between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.host_rd_en;
      if (bus.host_rd_en) begin
        rd_data <= rd_oor ? '0 : mem[rd_index];
      end
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.rd_valid    = rd_valid;
  assign bus.frame_ready = frame_ready;
  assign bus.frame_id    = frame_id;
  assign bus.drop_count  = drop_count;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_host_snapshot_buffer.sv
// Directed bench for host_snapshot_buffer with a 16-pixel frame.
module tb_host_snapshot_buffer;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int NC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  host_snapshot_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_CH(NC)) bus ();

  host_snapshot_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_CH(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pixel i of frame tag f: {rho, uy, ux}; tag 1 gives ux=i, uy=2i, rho=0x100+i.
  function automatic logic [47:0] pix(input int f, input int i);
    logic [15:0] ux, uy, rho;
    ux  = 16'(i + 32 * (f - 1));
    uy  = 16'(2 * i + 16 * (f - 1));
    rho = 16'(256 * f + i);
    return {rho, uy, ux};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int f, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pix(f, i);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    bus.host_rd_en = 1'b1;
    bus.host_addr  = a;
    tick();
    bus.host_rd_en = 1'b0;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    vectors++; if (bus.frame_ready !== 1'b0) begin miscompares++; $display("FAIL reset_frame_ready: got %b expected 0", bus.frame_ready); end
    vectors++; if (bus.frame_id !== 8'd0) begin miscompares++; $display("FAIL reset_frame_id: got %0d expected 0", bus.frame_id); end
    vectors++; if (bus.drop_count !== 16'd0) begin miscompares++; $display("FAIL reset_drop_count: got %0d expected 0", bus.drop_count); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    vectors++; if (bus.rd_data !== 48'd0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    send_pix(7, 0, 3);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_ignore_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.frame_id !== 8'd0) begin miscompares++; $display("FAIL idle_ignore_frame_id: got %0d expected 0", bus.frame_id); end
  endtask

  task automatic test_full_frame();
    start_frame();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL full_busy_capture: got %b expected 1", bus.busy); end
    send_pix(1, 0, 16);
    vectors++; if (bus.frame_ready !== 1'b1) begin miscompares++; $display("FAIL full_frame_ready: got %b expected 1", bus.frame_ready); end
    vectors++; if (bus.frame_id !== 8'd1) begin miscompares++; $display("FAIL full_frame_id: got %0d expected 1", bus.frame_id); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_idle: got %b expected 0", bus.busy); end
    do_read(5'd5);
    vectors++; if (bus.rd_valid !== 1'b1) begin miscompares++; $display("FAIL full_rd_valid: got %b expected 1", bus.rd_valid); end
    vectors++; if (bus.rd_data !== 48'h0105_000A_0005) begin miscompares++; $display("FAIL full_rd5: got %h expected 0105000a0005", bus.rd_data); end
    do_read(5'd15);
    vectors++; if (bus.rd_data !== pix(1, 15)) begin miscompares++; $display("FAIL full_rd15: got %h expected %h", bus.rd_data, pix(1, 15)); end
  endtask

  task automatic test_lock_pending();
    start_frame();
    send_pix(2, 0, 15);
    bus.host_lock = 1'b1;
    send_pix(2, 15, 1);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL pend_busy: got %b expected 1", bus.busy); end
    vectors++; if (bus.frame_ready !== 1'b0) begin miscompares++; $display("FAIL pend_ack_clears_ready: got %b expected 0", bus.frame_ready); end
    vectors++; if (bus.frame_id !== 8'd1) begin miscompares++; $display("FAIL pend_frame_id: got %0d expected 1", bus.frame_id); end
    bus.frame_start = 1'b1;
    send_pix(9, 0, 4);
    bus.frame_start = 1'b0;
    vectors++; if (bus.drop_count !== 16'd4) begin miscompares++; $display("FAIL pend_drop_count: got %0d expected 4", bus.drop_count); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL pend_busy_after_start: got %b expected 1", bus.busy); end
    do_read(5'd5);
    vectors++; if (bus.rd_data !== pix(1, 5)) begin miscompares++; $display("FAIL pend_old_frame: got %h expected %h", bus.rd_data, pix(1, 5)); end
    bus.host_lock  = 1'b0;
    bus.host_rd_en = 1'b1;
    bus.host_addr  = 5'd3;
    tick();
    bus.host_rd_en = 1'b0;
    vectors++; if (bus.rd_data !== pix(1, 3)) begin miscompares++; $display("FAIL swap_cycle_read: got %h expected %h", bus.rd_data, pix(1, 3)); end
    vectors++; if (bus.frame_id !== 8'd2) begin miscompares++; $display("FAIL pend_swap_id: got %0d expected 2", bus.frame_id); end
    vectors++; if (bus.frame_ready !== 1'b1) begin miscompares++; $display("FAIL pend_swap_ready: got %b expected 1", bus.frame_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL pend_swap_busy: got %b expected 0", bus.busy); end
    do_read(5'd5);
    vectors++; if (bus.rd_data !== pix(2, 5)) begin miscompares++; $display("FAIL pend_new_frame: got %h expected %h", bus.rd_data, pix(2, 5)); end
    vectors++; if (bus.drop_count !== 16'd4) begin miscompares++; $display("FAIL pend_drop_hold: got %0d expected 4", bus.drop_count); end
  endtask

  task automatic test_restart();
    start_frame();
    send_pix(4, 0, 7);
    bus.frame_start = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = pix(3, 0);
    tick();
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    vectors++; if (bus.frame_id !== 8'd2) begin miscompares++; $display("FAIL restart_no_swap: got %0d expected 2", bus.frame_id); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b expected 1", bus.busy); end
    send_pix(3, 1, 15);
    vectors++; if (bus.frame_id !== 8'd3) begin miscompares++; $display("FAIL restart_frame_id: got %0d expected 3", bus.frame_id); end
    for (int i = 0; i < 16; i++) begin
      do_read(5'(i));
      vectors++; if (bus.rd_data !== pix(3, i)) begin miscompares++; $display("FAIL restart_rd%0d: got %h expected %h", i, bus.rd_data, pix(3, i)); end
    end
  endtask

  task automatic test_back_to_back();
    bus.host_rd_en = 1'b1;
    bus.host_addr  = 5'd0;
    tick();
    bus.host_addr  = 5'd1;
    vectors++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, pix(3, 0)}) begin miscompares++; $display("FAIL b2b_rd0: got %b/%h expected 1/%h", bus.rd_valid, bus.rd_data, pix(3, 0)); end
    tick();
    bus.host_addr  = 5'd2;
    vectors++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, pix(3, 1)}) begin miscompares++; $display("FAIL b2b_rd1: got %b/%h expected 1/%h", bus.rd_valid, bus.rd_data, pix(3, 1)); end
    tick();
    bus.host_addr  = 5'd16;
    vectors++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, pix(3, 2)}) begin miscompares++; $display("FAIL b2b_rd2: got %b/%h expected 1/%h", bus.rd_valid, bus.rd_data, pix(3, 2)); end
    tick();
    bus.host_rd_en = 1'b0;
    vectors++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 48'd0}) begin miscompares++; $display("FAIL b2b_oor: got %b/%h expected 1/0", bus.rd_valid, bus.rd_data); end
    do_read(5'd7);
    tick();
    vectors++; if ({bus.rd_valid, bus.rd_data} !== {1'b0, pix(3, 7)}) begin miscompares++; $display("FAIL b2b_hold: got %b/%h expected 0/%h", bus.rd_valid, bus.rd_data, pix(3, 7)); end
  endtask

  task automatic test_reset_mid_capture();
    start_frame();
    send_pix(5, 0, 9);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.frame_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b expected 0", bus.frame_ready); end
    vectors++; if (bus.frame_id !== 8'd0) begin miscompares++; $display("FAIL midrst_frame_id: got %0d expected 0", bus.frame_id); end
    vectors++; if (bus.drop_count !== 16'd0) begin miscompares++; $display("FAIL midrst_drop: got %0d expected 0", bus.drop_count); end
    start_frame();
    send_pix(6, 0, 16);
    vectors++; if (bus.frame_id !== 8'd1) begin miscompares++; $display("FAIL midrst_next_id: got %0d expected 1", bus.frame_id); end
    vectors++; if (bus.frame_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_next_ready: got %b expected 1", bus.frame_ready); end
    do_read(5'd9);
    vectors++; if (bus.rd_data !== pix(6, 9)) begin miscompares++; $display("FAIL midrst_rd9: got %h expected %h", bus.rd_data, pix(6, 9)); end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.host_lock   = 1'b0;
    bus.host_rd_en  = 1'b0;
    bus.host_addr   = '0;
    test_reset();
    test_full_frame();
    test_lock_pending();
    test_restart();
    test_back_to_back();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
